// File: rtl/frame_buf_pkg.sv
// Shared definitions for the SDRAM frame-buffer clients (line writer and
// display line reader).
//
// Contents:
//   LINE_PIXELS / LINE_COUNT / BPP / LINE_BITS  line geometry
//   X_W / Y_W                                   pixel coordinate widths
//   colour_e                                    2-bit pixel colour codes
//   writer_state_e                              line writer FSM encoding
//   writer_op_e                                 why the writer left IDLE
//   set_pixel()                                 replace one pixel in a line
package frame_buf_pkg;

  localparam int LINE_PIXELS = 848;
  localparam int LINE_COUNT  = 480;
  localparam int BPP         = 2;
  localparam int LINE_BITS   = LINE_PIXELS * BPP;
  localparam int X_W         = 11;
  localparam int Y_W         = 9;

  typedef enum logic [1:0] {
    COL_BLACK = 2'd0,
    COL_RED   = 2'd1,
    COL_GREEN = 2'd2,
    COL_BLUE  = 2'd3
  } colour_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FLUSH_START = 3'd1,
    ST_FLUSH_WAIT  = 3'd2,
    ST_FETCH_START = 3'd3,
    ST_FETCH_WAIT  = 3'd4,
    ST_LOAD        = 3'd5,
    ST_DONE        = 3'd6
  } writer_state_e;

  typedef enum logic [1:0] {
    OP_MISS  = 2'd0,
    OP_FLUSH = 2'd1,
    OP_SWAP  = 2'd2
  } writer_op_e;

  // Pixel x lives in line[BPP*x +: BPP]. The loop keeps every slice index
  // constant, so the x decode becomes a plain one-hot write enable.
  function automatic logic [LINE_BITS-1:0] set_pixel(
    input logic [LINE_BITS-1:0] line,
    input logic [X_W-1:0]       x,
    input logic [BPP-1:0]       colour
  );
    logic [LINE_BITS-1:0] result;
    result = line;
    for (int i = 0; i < LINE_PIXELS; i++) begin
      if (x == X_W'(i)) begin
        result[BPP*i +: BPP] = colour;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_handshake.sv
// Start/Done handshake with the SDRAM memory controller.
//
// The controller's Done output may still be high from an earlier operation
// when a new start is issued, so an operation only completes once Done has
// been sampled low at least once after the start cycle and is then sampled
// high.
//
// Ports:
//   clk_i          clock shared with the memory controller
//   rst_i          asynchronous, active-high reset
//   start_i        high for the single cycle that launches an operation
//   mem_done_i     controller completion level
//   mem_start_o    start strobe to the controller
//   op_complete_o  one-cycle completion flag, valid in the cycle Done is
//                  sampled high after having been seen low
module mem_handshake (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic mem_done_i,
  output logic mem_start_o,
  output logic op_complete_o
);

  logic armed_q, armed_d;
  logic seen_low_q, seen_low_d;

  assign mem_start_o   = start_i;
  assign op_complete_o = armed_q & seen_low_q & mem_done_i;

  always_comb begin
    armed_d    = armed_q;
    seen_low_d = seen_low_q;
    if (start_i) begin
      // Done in the start cycle itself belongs to the previous operation.
      armed_d    = 1'b1;
      seen_low_d = 1'b0;
    end else if (op_complete_o) begin
      armed_d    = 1'b0;
      seen_low_d = 1'b0;
    end else if (armed_q && !mem_done_i) begin
      seen_low_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q    <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      seen_low_q <= seen_low_d;
    end
  end

endmodule

// File: rtl/frame_line_writer.sv
// Write-side client of the SDRAM frame buffer.
//
// Caches one full line. Single-pixel writes that hit the cached row update
// the cache directly (one pixel per cycle); a miss writes the dirty line back
// (if needed), fetches the new row and then applies the pending pixel.
// Flush writes the dirty line back; SwapBank additionally toggles the bank
// being drawn so the display can read the finished one.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | accepting pixels, flush and swap requests
// FLUSH_START  | start pulse for the write-back of the cached line
// FLUSH_WAIT   | waiting for write-back completion
// FETCH_START  | start pulse for the read of the pending row
// FETCH_WAIT   | waiting for read completion
// LOAD         | capture read data, apply pending pixel
// DONE         | one-cycle flush_done_o pulse
//
// Ports:
//   clk_i, reset_i              clock, asynchronous active-high reset
//   pixel_valid_i/pixel_ready_o pixel write handshake
//   pixel_x_i/y_i/color_i       pixel coordinates and colour
//   flush_i, swap_bank_i        level requests, dropped on flush_done_o
//   flush_done_o                one-cycle completion pulse
//   write_bank_o                bank being drawn (display uses the other)
//   busy_o                      FSM is not idle
//   mem_row_o, mem_bank_o       controller address
//   mem_in_o, mem_out_i         controller write / read data (whole line)
//   mem_write_o                 1 = write, 0 = read
//   mem_start_o, mem_done_i     controller start / completion
module frame_line_writer
  import frame_buf_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pixel_valid_i,
  output logic                 pixel_ready_o,
  input  logic [X_W-1:0]       pixel_x_i,
  input  logic [Y_W-1:0]       pixel_y_i,
  input  logic [BPP-1:0]       pixel_color_i,
  input  logic                 flush_i,
  input  logic                 swap_bank_i,
  output logic                 flush_done_o,
  output logic                 write_bank_o,
  output logic                 busy_o,
  output logic [Y_W-1:0]       mem_row_o,
  output logic [1:0]           mem_bank_o,
  output logic [LINE_BITS-1:0] mem_in_o,
  input  logic [LINE_BITS-1:0] mem_out_i,
  output logic                 mem_write_o,
  output logic                 mem_start_o,
  input  logic                 mem_done_i
);

  writer_state_e        state_q, state_d;
  writer_op_e           op_q, op_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [Y_W-1:0]       row_q, row_d;
  logic                 valid_q, valid_d;
  logic                 dirty_q, dirty_d;
  logic                 bank_q, bank_d;
  logic [X_W-1:0]       pend_x_q, pend_x_d;
  logic [Y_W-1:0]       pend_y_q, pend_y_d;
  logic [BPP-1:0]       pend_c_q, pend_c_d;

  logic start_req;
  logic op_complete;
  logic pixel_oob;
  logic pixel_hit;

  mem_handshake u_handshake (
    .clk_i         (clk_i),
    .rst_i         (reset_i),
    .start_i       (start_req),
    .mem_done_i    (mem_done_i),
    .mem_start_o   (mem_start_o),
    .op_complete_o (op_complete)
  );

  assign pixel_oob = (pixel_x_i >= X_W'(LINE_PIXELS)) ||
                     (pixel_y_i >= Y_W'(LINE_COUNT));
  assign pixel_hit = valid_q && (pixel_y_i == row_q);

  assign mem_in_o     = line_q;
  assign mem_bank_o   = {1'b0, bank_q};
  assign write_bank_o = bank_q;

  // State register and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MISS;
      line_q   <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      dirty_q  <= 1'b0;
      bank_q   <= 1'b0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      pend_c_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      line_q   <= line_d;
      row_q    <= row_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      bank_q   <= bank_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      pend_c_q <= pend_c_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    line_d   = line_q;
    row_d    = row_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    bank_d   = bank_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    pend_c_d = pend_c_q;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_i || swap_bank_i) begin
          // Requests take priority over pixels; swap implies a flush.
          op_d = swap_bank_i ? OP_SWAP : OP_FLUSH;
          if (dirty_q) begin
            state_d = ST_FLUSH_START;
          end else begin
            if (swap_bank_i) begin
              bank_d  = ~bank_q;
              valid_d = 1'b0;
            end
            state_d = ST_DONE;
          end
        end else if (pixel_valid_i && !pixel_oob) begin
          if (pixel_hit) begin
            line_d  = set_pixel(line_q, pixel_x_i, pixel_color_i);
            dirty_d = 1'b1;
          end else begin
            op_d     = OP_MISS;
            pend_x_d = pixel_x_i;
            pend_y_d = pixel_y_i;
            pend_c_d = pixel_color_i;
            state_d  = dirty_q ? ST_FLUSH_START : ST_FETCH_START;
          end
        end
      end

      ST_FLUSH_START: state_d = ST_FLUSH_WAIT;

      ST_FLUSH_WAIT: begin
        if (op_complete) begin
          dirty_d = 1'b0;
          unique case (op_q)
            OP_MISS: state_d = ST_FETCH_START;
            OP_SWAP: begin
              bank_d  = ~bank_q;
              valid_d = 1'b0;
              state_d = ST_DONE;
            end
            default: state_d = ST_DONE;
          endcase
        end
      end

      ST_FETCH_START: state_d = ST_FETCH_WAIT;

      ST_FETCH_WAIT: begin
        if (op_complete) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // The freshly read line already differs from memory once the
        // pending pixel lands in it.
        line_d  = set_pixel(mem_out_i, pend_x_q, pend_c_q);
        row_d   = pend_y_q;
        valid_d = 1'b1;
        dirty_d = 1'b1;
        state_d = ST_IDLE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state. Row, bank, direction and data
  // depend only on state and registers, so they hold steady from the start
  // pulse until the operation completes.
  always_comb begin
    pixel_ready_o = 1'b0;
    busy_o        = 1'b1;
    start_req     = 1'b0;
    mem_write_o   = 1'b0;
    mem_row_o     = '0;
    flush_done_o  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_o        = 1'b0;
        pixel_ready_o = !reset_i && !flush_i && !swap_bank_i;
      end
      ST_FLUSH_START: begin
        start_req   = 1'b1;
        mem_write_o = 1'b1;
        mem_row_o   = row_q;
      end
      ST_FLUSH_WAIT: begin
        mem_write_o = 1'b1;
        mem_row_o   = row_q;
      end
      ST_FETCH_START: begin
        start_req = 1'b1;
        mem_row_o = pend_y_q;
      end
      ST_FETCH_WAIT: begin
        mem_row_o = pend_y_q;
      end
      ST_DONE: begin
        flush_done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
